// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for a 5-stage (F/D/E/M/W) RISC-V pipeline.
//   - Forwarding selects for the D->E operands (priority E > M > W, rd == x0 never forwards).
//   - Load-use detection: stalls F/D for one cycle and inserts an E bubble.
//   - Mispredict handling: one-cycle redirect, then flush_fd held for FLUSH_CYCLES cycles in total.
//   - Freezes the pipeline (HALT) once an ebreak retires in W. Only reset leaves HALT.
//   - Saturating performance counters for load-use stall cycles and accepted mispredicts.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   d_* / e_* / m_* / w_*               per-stage valid, register indices and write enables
//   ex_mispredict, ex_target            mispredict resolved in E and the correct pc
//   fwd_a_sel, fwd_b_sel                operand source: 0 regfile, 1 E, 2 M, 3 W
//   stall_fd, bubble_e, flush_fd        pipeline control, combinational in the current state
//   redirect_valid, redirect_pc         pc redirect request
//   halted                              pipeline frozen after ebreak
//   stall_cnt, flush_cnt                saturating performance counters
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic             e_valid,
    input  logic [6:0]       e_opcode,
    input  logic [4:0]       e_rd,
    input  logic             e_wen,
    input  logic             m_valid,
    input  logic [4:0]       m_rd,
    input  logic             m_wen,
    input  logic             w_valid,
    input  logic [4:0]       w_rd,
    input  logic             w_wen,
    input  logic             w_ebreak,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_target,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_fd,
    output logic             bubble_e,
    output logic             flush_fd,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [FC_W-1:0] fcnt;
    logic [FC_W-1:0] fcnt_nxt;
    logic            stall_inc;
    logic            flush_inc;

    logic e_wr;
    logic m_wr;
    logic w_wr;
    logic lu;

    // A stage can only forward when it really writes a non-zero register.
    assign e_wr = e_valid & e_wen & (e_rd != 5'd0);
    assign m_wr = m_valid & m_wen & (m_rd != 5'd0);
    assign w_wr = w_valid & w_wen & (w_rd != 5'd0);

    // Load in E whose result is needed by D: the value is not available until M.
    assign lu = e_wr & (e_opcode == OP_LOAD) & d_valid &
                ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       e_ok, input logic [4:0] e_r,
        input logic       m_ok, input logic [4:0] m_r,
        input logic       w_ok, input logic [4:0] w_r
    );
        if (e_ok && (e_r == rs))      fwd_sel = 2'd1;
        else if (m_ok && (m_r == rs)) fwd_sel = 2'd2;
        else if (w_ok && (w_r == rs)) fwd_sel = 2'd3;
        else                          fwd_sel = 2'd0;
    endfunction

    // Forwarding selects, youngest producer wins.
    always_comb begin
        fwd_a_sel = fwd_sel(d_rs1, e_wr, e_rd, m_wr, m_rd, w_wr, w_rd);
        fwd_b_sel = fwd_sel(d_rs2, e_wr, e_rd, m_wr, m_rd, w_wr, w_rd);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            fcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Next state and pipeline control.
    always_comb begin
        state_nxt      = state;
        fcnt_nxt       = fcnt;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        stall_fd       = 1'b0;
        bubble_e       = 1'b0;
        flush_fd       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (state)
            ST_RUN: begin
                if (ex_mispredict) begin
                    // Redirect wins over load-use: the stalled D instruction is wrong-path.
                    redirect_valid = 1'b1;
                    redirect_pc    = ex_target;
                    flush_fd       = 1'b1;
                    bubble_e       = 1'b1;
                    flush_inc      = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (lu) begin
                    stall_fd  = 1'b1;
                    bubble_e  = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Everything in F/D/E is wrong-path here; ignore mispredicts and load-use.
                flush_fd = 1'b1;
                bubble_e = 1'b1;
                fcnt_nxt = fcnt - FC_W'(1);
                if (fcnt <= FC_W'(1)) state_nxt = ST_RUN;
            end
            ST_HALT: begin
                stall_fd = 1'b1;
                bubble_e = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase

        // A retiring ebreak overrides any other next state.
        if (w_valid && w_ebreak) state_nxt = ST_HALT;

        // Keep control quiet while reset is held, regardless of the inputs.
        if (!rst_n) begin
            stall_inc      = 1'b0;
            flush_inc      = 1'b0;
            stall_fd       = 1'b0;
            bubble_e       = 1'b0;
            flush_fd       = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
        end
    end

    assign halted = (state == ST_HALT);

endmodule
